// File: rtl/noc_pkg.sv
// Shared NoC types: flit type encoding, arbiter state and the flit-type decode helper.
package noc_pkg;

    localparam int unsigned FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Caller hands over the flit's top FLIT_TYPE_W bits, keeping this independent of flit width.
    function automatic flit_type_e flit_type(input logic [FLIT_TYPE_W-1:0] flit_top);
        return flit_type_e'(flit_top);
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin pick: first request strictly after ptr, wrapping modulo NUM_IN.
module noc_rr_pick #(
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned GID_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [GID_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [GID_W-1:0]  idx,
    output logic              found
);

    logic [GID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            // Explicit wrap so non-power-of-2 NUM_IN never visits an unused index.
            cand = (cand >= GID_W'(NUM_IN - 1)) ? '0 : cand + GID_W'(1);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        grant[idx] = found;
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: round-robin packet grant over show-ahead input FIFOs,
// lock held head-to-tail, registered valid/ready flit output.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned NUM_IN     = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned GID_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            in_empty,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
    output logic [NUM_IN-1:0]            in_rd_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_flit,
    output logic [GID_W-1:0]             grant_id,
    output logic                         busy,
    output logic                         proto_err
);

    arb_state_e state, state_next;
    logic [GID_W-1:0] last_grant;

    logic [DATA_WIDTH-1:0] head  [NUM_IN];
    flit_type_e            ftype [NUM_IN];
    logic [NUM_IN-1:0]     elig;
    logic [NUM_IN-1:0]     bad_idle;

    logic [NUM_IN-1:0] pick_grant;
    logic [GID_W-1:0]  pick_idx;
    logic              pick_found;

    logic             ld_ok;
    logic             load;
    logic [GID_W-1:0] sel;
    logic             err;
    logic             locked_avail;
    flit_type_e       locked_type;

    // Per-input head decode: eligibility to start a packet and idle-time framing errors.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_dec
        assign head[i]     = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
        assign ftype[i]    = flit_type(head[i][DATA_WIDTH-1 -: FLIT_TYPE_W]);
        assign elig[i]     = !in_empty[i] && (ftype[i] == HEAD || ftype[i] == SINGLE);
        assign bad_idle[i] = !in_empty[i] && (ftype[i] == BODY || ftype[i] == TAIL);
    end

    noc_rr_pick #(
        .NUM_IN (NUM_IN),
        .GID_W  (GID_W)
    ) u_pick (
        .req   (elig),
        .ptr   (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign ld_ok        = !out_valid || out_ready;
    assign locked_avail = !in_empty[grant_id];
    assign locked_type  = ftype[grant_id];
    assign busy         = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_found && ld_ok && ftype[pick_idx] == HEAD) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (locked_avail && ld_ok && locked_type == TAIL) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pop/load decode; pop is combinational because the FIFOs are show-ahead.
    always_comb begin
        in_rd_en = '0;
        load     = 1'b0;
        sel      = grant_id;
        err      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    err = |bad_idle;
                    if (pick_found && ld_ok) begin
                        in_rd_en = pick_grant;
                        load     = 1'b1;
                        sel      = pick_idx;
                    end
                end
                LOCKED: begin
                    if (locked_avail) begin
                        err = (locked_type == HEAD || locked_type == SINGLE);
                        if (ld_ok) begin
                            in_rd_en[grant_id] = 1'b1;
                            load               = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_flit   <= '0;
            grant_id   <= '0;
            last_grant <= GID_W'(NUM_IN - 1);
            proto_err  <= 1'b0;
        end else begin
            if (ld_ok) begin
                out_valid <= load;
                if (load) begin
                    out_flit <= head[sel];
                end
            end
            if (load && state == IDLE) begin
                last_grant <= sel;
                grant_id   <= sel;
            end
            if (err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter: queue-modelled show-ahead FIFOs, directed packets.
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam int unsigned NUM_IN = 5;
    localparam int unsigned DW     = 64;
    localparam int unsigned GW     = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_IN-1:0]    in_empty;
    logic [NUM_IN*DW-1:0] in_dout;
    logic [NUM_IN-1:0]    in_rd_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_flit;
    logic [GW-1:0]        grant_id;
    logic                 busy;
    logic                 proto_err;

    logic [DW-1:0] fifo_q [NUM_IN][$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] dout_arr [NUM_IN];
    logic          empty_arr [NUM_IN];
    logic [NUM_IN-1:0] last_rd;
    logic          rst_at_edge;
    logic [DW-1:0] exp_flit;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
        assign in_dout[g*DW +: DW] = dout_arr[g];
        assign in_empty[g]         = empty_arr[g];
    end

    noc_output_arbiter #(
        .NUM_IN     (NUM_IN),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .in_rd_en  (in_rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .grant_id  (grant_id),
        .busy      (busy),
        .proto_err (proto_err)
    );

    function automatic logic [DW-1:0] mk(input flit_type_e t, input int src, input int seq);
        return {t, 54'd0, 4'(src), 4'(seq)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NUM_IN; i++) begin
            empty_arr[i] = (fifo_q[i].size() == 0);
            dout_arr[i]  = (fifo_q[i].size() == 0) ? '0 : fifo_q[i][0];
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] f);
        fifo_q[i].push_back(f);
        refresh();
    endtask

    task automatic expect_flit(input logic [DW-1:0] f);
        exp_q.push_back(f);
    endtask

    // One clock: capture pops before the edge, apply them to the FIFO model after it.
    task automatic tick();
        @(negedge clk);
        last_rd     = in_rd_en;
        rst_at_edge = rst;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rst_at_edge) begin
                fifo_q[i].delete();
            end else if (last_rd[i]) begin
                checks++;
                if (fifo_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty: in_rd_en[%0d]=1 with empty FIFO", i);
                end else begin
                    void'(fifo_q[i].pop_front());
                end
            end
        end
        refresh();
    endtask

    task automatic step(input string name, input logic [NUM_IN-1:0] exp_rd);
        tick();
        chk(name, DW'(last_rd), DW'(exp_rd));
    endtask

    // Monitor: every accepted output flit is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got %0h expected none", out_flit);
            end else begin
                exp_flit = exp_q.pop_front();
                if (out_flit !== exp_flit) begin
                    errors++;
                    $display("FAIL out_flit: got %0h expected %0h", out_flit, exp_flit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        refresh();
        tick();
        tick();
        chk("rst_rd_en", DW'(last_rd), '0);
        rst = 1'b0;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_flit", out_flit, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_grant_id", DW'(grant_id), '0);
        chk("rst_proto_err", DW'(proto_err), '0);

        // Two 3-flit packets on inputs 0 and 3, back to back.
        for (int s = 0; s < 3; s++) push(0, mk(s == 0 ? HEAD : (s == 1 ? BODY : TAIL), 0, s));
        for (int s = 0; s < 3; s++) push(3, mk(s == 0 ? HEAD : (s == 1 ? BODY : TAIL), 3, s));
        for (int s = 0; s < 3; s++) expect_flit(mk(s == 0 ? HEAD : (s == 1 ? BODY : TAIL), 0, s));
        for (int s = 0; s < 3; s++) expect_flit(mk(s == 0 ? HEAD : (s == 1 ? BODY : TAIL), 3, s));
        step("pkt_0h", 5'b00001);
        chk("pkt_busy_0", DW'(busy), 1);
        chk("pkt_gid_0", DW'(grant_id), 0);
        step("pkt_0b", 5'b00001);
        step("pkt_0t", 5'b00001);
        step("pkt_3h", 5'b01000);
        chk("pkt_busy_3", DW'(busy), 1);
        chk("pkt_gid_3", DW'(grant_id), 3);
        step("pkt_3b", 5'b01000);
        step("pkt_3t", 5'b01000);
        chk("pkt_busy_end", DW'(busy), 0);

        // Single-flit packet on input 2.
        push(2, mk(SINGLE, 2, 0));
        expect_flit(mk(SINGLE, 2, 0));
        step("single_rd", 5'b00100);
        chk("single_valid", DW'(out_valid), 1);
        chk("single_busy", DW'(busy), 0);
        step("single_idle_rd", 5'b00000);
        chk("single_drop_valid", DW'(out_valid), 0);

        // Lock hold on input 1 while input 4 waits with a HEAD.
        push(1, mk(HEAD, 1, 0));
        push(1, mk(BODY, 1, 1));
        expect_flit(mk(HEAD, 1, 0));
        expect_flit(mk(BODY, 1, 1));
        expect_flit(mk(TAIL, 1, 2));
        expect_flit(mk(HEAD, 4, 0));
        expect_flit(mk(TAIL, 4, 1));
        step("hold_1h", 5'b00010);
        step("hold_1b", 5'b00010);
        push(4, mk(HEAD, 4, 0));
        push(4, mk(TAIL, 4, 1));
        step("hold_bubble1", 5'b00000);
        chk("hold_bubble_valid", DW'(out_valid), 0);
        chk("hold_busy", DW'(busy), 1);
        chk("hold_gid", DW'(grant_id), 1);
        step("hold_bubble2", 5'b00000);
        chk("hold_no_err", DW'(proto_err), 0);
        push(1, mk(TAIL, 1, 2));
        step("hold_resume", 5'b00010);
        step("hold_4h", 5'b10000);
        step("hold_4t", 5'b10000);

        // Backpressure for 3 cycles mid-packet.
        push(0, mk(HEAD, 0, 0));
        push(0, mk(BODY, 0, 1));
        push(0, mk(BODY, 0, 2));
        push(0, mk(TAIL, 0, 3));
        expect_flit(mk(HEAD, 0, 0));
        expect_flit(mk(BODY, 0, 1));
        expect_flit(mk(BODY, 0, 2));
        expect_flit(mk(TAIL, 0, 3));
        step("bp_h", 5'b00001);
        step("bp_b1", 5'b00001);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("bp_stall_rd", 5'b00000);
            chk("bp_stall_flit", out_flit, mk(BODY, 0, 1));
            chk("bp_stall_valid", DW'(out_valid), 1);
        end
        out_ready = 1'b1;
        step("bp_b2", 5'b00001);
        step("bp_t", 5'b00001);

        // BODY at the head of input 2 while idle.
        push(2, mk(BODY, 2, 0));
        push(1, mk(SINGLE, 1, 0));
        expect_flit(mk(SINGLE, 1, 0));
        step("perr_rd", 5'b00010);
        chk("perr_set", DW'(proto_err), 1);
        push(3, mk(SINGLE, 3, 0));
        expect_flit(mk(SINGLE, 3, 0));
        step("perr_other", 5'b01000);
        step("perr_no_pop2", 5'b00000);
        chk("perr_sticky", DW'(proto_err), 1);

        rst = 1'b1;
        step("rst_gate", 5'b00000);
        rst = 1'b0;
        chk("rst2_proto_err", DW'(proto_err), 0);
        chk("rst2_valid", DW'(out_valid), 0);

        // Fairness over five SINGLE sources, then reset in the middle of a packet.
        push(0, mk(SINGLE, 0, 0));
        push(0, mk(SINGLE, 0, 1));
        push(0, mk(HEAD, 0, 2));
        push(0, mk(BODY, 0, 3));
        push(0, mk(TAIL, 0, 4));
        for (int i = 1; i < NUM_IN; i++) push(i, mk(SINGLE, i, 0));
        for (int i = 0; i < NUM_IN; i++) expect_flit(mk(SINGLE, i, 0));
        expect_flit(mk(SINGLE, 0, 1));
        expect_flit(mk(HEAD, 0, 2));
        step("fair_0", 5'b00001);
        step("fair_1", 5'b00010);
        step("fair_2", 5'b00100);
        step("fair_3", 5'b01000);
        step("fair_4", 5'b10000);
        step("fair_0_again", 5'b00001);
        step("fair_head", 5'b00001);
        chk("fair_busy", DW'(busy), 1);
        step("fair_body", 5'b00001);
        rst = 1'b1;
        step("rst_mid_rd", 5'b00000);
        chk("rst_mid_valid", DW'(out_valid), 0);
        chk("rst_mid_flit", out_flit, '0);
        chk("rst_mid_busy", DW'(busy), 0);
        chk("rst_mid_gid", DW'(grant_id), 0);
        rst = 1'b0;
        push(2, mk(SINGLE, 2, 5));
        push(0, mk(SINGLE, 0, 5));
        expect_flit(mk(SINGLE, 0, 5));
        expect_flit(mk(SINGLE, 2, 5));
        step("post_rst_first", 5'b00001);
        step("post_rst_second", 5'b00100);

        // HEAD then SINGLE on a locked input: error flagged, flit forwarded, lock kept.
        push(1, mk(HEAD, 1, 6));
        push(1, mk(SINGLE, 1, 7));
        expect_flit(mk(HEAD, 1, 6));
        expect_flit(mk(SINGLE, 1, 7));
        expect_flit(mk(TAIL, 1, 8));
        step("lerr_h", 5'b00010);
        chk("lerr_clear", DW'(proto_err), 0);
        step("lerr_s", 5'b00010);
        chk("lerr_set", DW'(proto_err), 1);
        chk("lerr_busy", DW'(busy), 1);
        push(1, mk(TAIL, 1, 8));
        step("lerr_t", 5'b00010);
        chk("lerr_unlock", DW'(busy), 0);

        repeat (3) tick();
        chk("scoreboard_drained", DW'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
